// File: rtl/serial_word_tx.sv
// serial_word_tx: sends parallel words MSB first to the MBED over a
// four-phase data_ready/data_ack bit handshake, with setup hold-off and
// per-edge timeout.
`timescale 1ns/1ps
module serial_word_tx #(
    parameter int unsigned WIDTH          = 10,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_in,
    output logic             word_ready,
    input  logic             data_ack,
    output logic             data_bit,
    output logic             data_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam bit            TO_EN      = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [SW-1:0]    setup_cnt_q;
    logic [TW-1:0]    to_cnt_q;
    logic             ack_meta_q;
    logic             ack_s_q;
    logic             data_bit_q;
    logic             data_ready_q;
    logic             done_q;
    logic             timeout_err_q;

    logic [WIDTH-1:0] sh_next_d;
    logic [TW-1:0]    to_cnt_d;
    logic             waiting;
    logic             to_abort;

    // Next shift value, timeout increment, and whether the current cycle is
    // spent blocked on an ack edge (the only time the timeout advances).
    always_comb begin
        sh_next_d = sh_q << 1;
        to_cnt_d  = to_cnt_q + 1'b1;
        waiting   = ((state_q == SETUP) && (setup_cnt_q == SETUP_LAST) && ack_s_q) ||
                    ((state_q == WAIT_HI) && !ack_s_q) ||
                    ((state_q == WAIT_LO) && ack_s_q);
        to_abort  = TO_EN && waiting && (to_cnt_q == TO_LAST);
    end

    // Two-flop synchronizer for the asynchronous MBED acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= data_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Handshake FSM; data_bit only moves on entry to SETUP or IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sh_q          <= '0;
            bit_cnt_q     <= '0;
            setup_cnt_q   <= '0;
            to_cnt_q      <= '0;
            data_bit_q    <= 1'b0;
            data_ready_q  <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            if (to_abort) begin
                // Abandon the word from whichever blocked state we are in.
                state_q       <= IDLE;
                data_ready_q  <= 1'b0;
                data_bit_q    <= 1'b0;
                to_cnt_q      <= '0;
                timeout_err_q <= 1'b1;
            end else begin
                if (waiting) begin
                    to_cnt_q <= to_cnt_d;
                end
                case (state_q)
                    IDLE: begin
                        if (word_valid) begin
                            sh_q        <= word_in;
                            bit_cnt_q   <= '0;
                            setup_cnt_q <= '0;
                            to_cnt_q    <= '0;
                            data_bit_q  <= word_in[WIDTH-1];
                            state_q     <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (setup_cnt_q != SETUP_LAST) begin
                            setup_cnt_q <= setup_cnt_q + 1'b1;
                        end else if (!ack_s_q) begin
                            data_ready_q <= 1'b1;
                            to_cnt_q     <= '0;
                            state_q      <= WAIT_HI;
                        end
                    end
                    WAIT_HI: begin
                        if (ack_s_q) begin
                            data_ready_q <= 1'b0;
                            to_cnt_q     <= '0;
                            state_q      <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        if (!ack_s_q) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            to_cnt_q  <= '0;
                            if (bit_cnt_q == BIT_LAST) begin
                                data_bit_q <= 1'b0;
                                done_q     <= 1'b1;
                                state_q    <= IDLE;
                            end else begin
                                sh_q        <= sh_next_d;
                                data_bit_q  <= sh_next_d[WIDTH-1];
                                setup_cnt_q <= '0;
                                state_q     <= SETUP;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign word_ready  = (state_q == IDLE) && !reset;
    assign busy        = (state_q != IDLE);
    assign data_bit    = data_bit_q;
    assign data_ready  = data_ready_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: expected line waveform built per word from the
// bit values and the per-bit handshake timing, plus directed literal checks.
`timescale 1ns/1ps
module tb_serial_word_tx;

    localparam int unsigned W  = 10;
    localparam int unsigned S  = 4;
    localparam int unsigned TO = 100;
    localparam int unsigned A  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         word_valid;
    logic [W-1:0] word_in;
    logic         word_ready;
    logic         data_ack;
    logic         data_bit;
    logic         data_ready;
    logic         busy;
    logic         done;
    logic         timeout_err;

    serial_word_tx #(
        .WIDTH(W),
        .SETUP_CYCLES(S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .word_valid(word_valid),
        .word_in(word_in),
        .word_ready(word_ready),
        .data_ack(data_ack),
        .data_bit(data_bit),
        .data_ready(data_ready),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle line state.
    typedef struct packed {
        logic busy;
        logic rdy;
        logic bit_v;
        logic dn;
    } exp_t;

    function automatic exp_t mk(input logic b, input logic r, input logic d, input logic n);
        exp_t e;
        e.busy  = b;
        e.rdy   = r;
        e.bit_v = d;
        e.dn    = n;
        return e;
    endfunction

    exp_t exp_q[$];
    bit   model_en = 1'b0;
    int   ack_mode = 0;   // 0: MBED answers after A cycles, 1: ack held low, 2: ack held high

    // Each bit: S setup cycles, then high and low phases of A+3 cycles each
    // (A-cycle MBED response plus 2 synchronizer cycles plus 1 FSM cycle).
    task automatic plan_word(input logic [W-1:0] w);
        for (int i = int'(W) - 1; i >= 0; i--) begin
            for (int c = 0; c < int'(S); c++)     exp_q.push_back(mk(1'b1, 1'b0, w[i], 1'b0));
            for (int c = 0; c < int'(A) + 3; c++) exp_q.push_back(mk(1'b1, 1'b1, w[i], 1'b0));
            for (int c = 0; c < int'(A) + 3; c++) exp_q.push_back(mk(1'b1, 1'b0, w[i], 1'b0));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    logic strobe_q[$];
    int   n_done = 0;
    int   n_terr = 0;

    // MBED acknowledge model.
    initial begin
        logic last;
        int   cnt;
        last     = 1'b0;
        cnt      = 1000;
        data_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (data_ready !== last) begin
                last = data_ready;
                cnt  = 0;
            end else if (cnt < 1000) begin
                cnt++;
            end
            if (ack_mode == 1)      data_ack = 1'b0;
            else if (ack_mode == 2) data_ack = 1'b1;
            else if (cnt >= int'(A)) data_ack = last;
        end
    end

    // Compare process: line bookkeeping every cycle, model compare when enabled.
    initial begin
        logic prev_rdy;
        logic held_bit;
        exp_t e;
        prev_rdy = 1'b0;
        held_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (data_ready && !prev_rdy) begin
                strobe_q.push_back(data_bit);
                held_bit = data_bit;
            end
            if (data_ready && prev_rdy) check("bit_stable", data_bit, held_bit);
            prev_rdy = data_ready;
            if (done) n_done++;
            if (timeout_err) n_terr++;
            if (model_en) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b0);
                check("m_busy", busy, e.busy);
                check("m_ready", data_ready, e.rdy);
                check("m_bit", data_bit, e.bit_v);
                check("m_done", done, e.dn);
                check("m_word_ready", word_ready, !e.busy);
                check("m_timeout", timeout_err, 1'b0);
                if (!e.busy && word_valid && !reset) plan_word(word_in);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        word_valid = 1'b1;
        word_in    = w;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic check_word_bits(input string name, input logic [W-1:0] w, input int base);
        for (int i = 0; i < int'(W); i++) begin
            if (base + i < strobe_q.size()) check(name, strobe_q[base + i], w[int'(W) - 1 - i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] pat;
        int n;
        int hi;
        logic saw;

        reset      = 1'b1;
        word_valid = 1'b0;
        word_in    = '0;
        repeat (2) tick();
        check("rst_word_ready", word_ready, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_data_bit", data_bit, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);

        // Reset and word_valid together: no accept.
        word_valid = 1'b1;
        word_in    = 10'h2A5;
        tick();
        check("rst_vs_valid_busy", busy, 1'b0);
        reset      = 1'b0;
        word_valid = 1'b0;
        tick();
        check("rel_word_ready", word_ready, 1'b1);
        check("rel_busy", busy, 1'b0);

        // Single word 2A5 with a 3-cycle MBED.
        exp_q.delete();
        model_en = 1'b1;
        strobe_q.delete();
        n_done = 0;
        n_terr = 0;
        send(10'h2A5);
        check("t1_busy", busy, 1'b1);
        check("t1_msb", data_bit, 1'b1);
        repeat (S - 1) tick();
        check("t1_rdy_before", data_ready, 1'b0);
        tick();
        check("t1_rdy_rise", data_ready, 1'b1);
        wait_done("t1_done_seen", 400);
        tick();
        pat = 10'b1010100101;
        check("t1_strobes", strobe_q.size(), 10);
        check_word_bits("t1_bits", pat, 0);
        check("t1_n_done", n_done, 1);

        // Back-to-back 3FF then 000; 0F0 offered mid-word must be ignored.
        strobe_q.delete();
        n_done = 0;
        send(10'h3FF);
        repeat (30) tick();
        word_valid = 1'b1;
        word_in    = 10'h0F0;
        tick();
        word_valid = 1'b0;
        wait_done("t2_done1_seen", 400);
        word_valid = 1'b1;
        word_in    = 10'h000;
        tick();
        check("t2_accept_on_done", busy, 1'b1);
        word_valid = 1'b0;
        wait_done("t2_done2_seen", 400);
        tick();
        check("t2_strobes", strobe_q.size(), 20);
        check_word_bits("t2_bits_a", 10'h3FF, 0);
        check_word_bits("t2_bits_b", 10'h000, 10);
        check("t2_n_done", n_done, 2);

        // Timeout with ack held low.
        model_en = 1'b0;
        ack_mode = 1;
        n_done   = 0;
        n_terr   = 0;
        send(10'h2A5);
        n = 0;
        while (!data_ready && n < 20) begin
            tick();
            n++;
        end
        check("t3_rdy_rise", data_ready, 1'b1);
        hi = 1;
        while (data_ready && hi < 300) begin
            tick();
            if (data_ready) hi++;
        end
        check("t3_high_cycles", hi, TO);
        check("t3_timeout_pulse", timeout_err, 1'b1);
        check("t3_no_done", done, 1'b0);
        check("t3_word_ready", word_ready, 1'b1);
        check("t3_bit_low", data_bit, 1'b0);
        tick();
        check("t3_timeout_one_cycle", timeout_err, 1'b0);
        check("t3_n_terr", n_terr, 1);
        check("t3_n_done", n_done, 0);
        ack_mode = 0;
        repeat (5) tick();

        // Ack stuck high when 155 is accepted.
        ack_mode = 2;
        repeat (4) tick();
        strobe_q.delete();
        n_done = 0;
        n_terr = 0;
        send(10'h155);
        saw = 1'b0;
        repeat (20) begin
            tick();
            if (data_ready) saw = 1'b1;
        end
        check("t4_held_off", saw, 1'b0);
        check("t4_busy", busy, 1'b1);
        ack_mode = 0;
        repeat (2) tick();
        check("t4_rdy_not_yet", data_ready, 1'b0);
        tick();
        check("t4_rdy_after_3", data_ready, 1'b1);
        wait_done("t4_done_seen", 400);
        tick();
        check("t4_strobes", strobe_q.size(), 10);
        check_word_bits("t4_bits", 10'h155, 0);
        check("t4_n_done", n_done, 1);
        check("t4_n_terr", n_terr, 0);

        // Reset during WAIT_HI of bit 4, then a clean 2A5.
        n_done = 0;
        strobe_q.delete();
        send(10'h2A5);
        n = 0;
        while (strobe_q.size() < 5 && n < 500) begin
            tick();
            n++;
        end
        check("t5_in_wait_hi", data_ready, 1'b1);
        reset = 1'b1;
        tick();
        check("t5_rdy", data_ready, 1'b0);
        check("t5_bit", data_bit, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_word_ready", word_ready, 1'b0);
        reset = 1'b0;
        repeat (12) tick();
        check("t5_no_done", n_done, 0);
        check("t5_idle", busy, 1'b0);
        exp_q.delete();
        model_en = 1'b1;
        strobe_q.delete();
        send(10'h2A5);
        check("t5_msb", data_bit, 1'b1);
        wait_done("t5_done_seen", 400);
        tick();
        check("t5_strobes", strobe_q.size(), 10);
        check_word_bits("t5_bits", 10'h2A5, 0);
        check("t5_n_done", n_done, 1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
